// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, instruction field positions, reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned JIDX_HI  = 25;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: jump target formation, jump-over-branch priority and alignment check.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0]      pc_plus4,
  input  logic [JIDX_HI:0] jidx,
  input  logic             pc_src,
  input  logic             jump,
  input  logic [31:0]      branch_target,
  output logic [31:0]      next_pc,
  output logic             misaligned
);

  logic [31:0] jtarget;

  always_comb begin
    jtarget = {pc_plus4[31:28], jidx, 2'b00};
    if (jump) begin
      next_pc = jtarget;
    end else if (pc_src) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IR and retired counter with a req/ack imem handshake.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = mips_pkg::RESET_PC,
  // Reset value of the retired counter; nonzero only to exercise wrap-around.
  parameter logic [31:0] RETIRED_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_plus4,
  input  logic        pc_src,
  input  logic        jump,
  input  logic [31:0] branch_target,
  output logic        fault,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  next_pc;
  logic         misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next u_pc_next (
    .pc_plus4      (pc_plus4),
    .jidx          (instr_q[JIDX_HI:0]),
    .pc_src        (pc_src),
    .jump          (jump),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          if (misaligned) begin
            state_d = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      retired_q <= RETIRED_RESET;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Handshake outputs are decoded from state only, never from inputs.
  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StIssue);
  assign fault       = (state_q == StHalt);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_HI:OP_LO];
  assign funct       = instr_q[FUNCT_HI:FUNCT_LO];
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction stream.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        pc_src;
  logic        jump;
  logic [31:0] branch_target;

  logic        imem_req, instr_valid, fault;
  logic [31:0] imem_addr, instr, pc_plus4, retired;
  logic [5:0]  op, funct;

  logic        w_imem_req, w_instr_valid, w_fault;
  logic [31:0] w_imem_addr, w_instr, w_pc_plus4, w_retired;
  logic [5:0]  w_op, w_funct;

  int total = 0;
  int bad   = 0;

  // Reference state: what the fetch stage should hold between steps.
  logic [31:0] m_pc, m_instr, m_ret;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .op            (op),
    .funct         (funct),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_plus4      (pc_plus4),
    .pc_src        (pc_src),
    .jump          (jump),
    .branch_target (branch_target),
    .fault         (fault),
    .retired       (retired)
  );

  fetch_unit #(
    .RESET_PC      (32'hFFFF_FFFC),
    .RETIRED_RESET (32'hFFFF_FFFF)
  ) dut_w (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (w_imem_req),
    .imem_addr     (w_imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (w_instr),
    .op            (w_op),
    .funct         (w_funct),
    .instr_valid   (w_instr_valid),
    .instr_ready   (instr_ready),
    .pc_plus4      (w_pc_plus4),
    .pc_src        (pc_src),
    .jump          (jump),
    .branch_target (branch_target),
    .fault         (w_fault),
    .retired       (w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic junk_decisions();
    pc_src        = 1'($urandom);
    jump          = 1'($urandom);
    branch_target = $urandom;
  endtask

  task automatic do_reset(input int cycles, input bit stale_ack);
    for (int i = 0; i < cycles; i++) begin
      reset       = 1'b1;
      imem_ack    = stale_ack;
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      junk_decisions();
      step();
      chk("rst_req",     {31'd0, imem_req},    32'd0);
      chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
      chk("rst_fault",   {31'd0, fault},       32'd0);
      chk("rst_addr",    imem_addr,            32'd0);
      chk("rst_instr",   instr,                32'd0);
      chk("rst_retired", retired,              32'd0);
    end
    reset   = 1'b0;
    m_pc    = 32'd0;
    m_instr = 32'd0;
    m_ret   = 32'd0;
  endtask

  task automatic do_idle(input bit stale_ack);
    chk("idle_req",   {31'd0, imem_req},    32'd0);
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_instr", instr,                m_instr);
    imem_ack    = stale_ack;
    imem_rdata  = $urandom;
    instr_ready = 1'($urandom);
    junk_decisions();
    step();
  endtask

  task automatic do_fetch(input int waits, input logic [31:0] data);
    for (int i = 0; i <= waits; i++) begin
      chk("fetch_req",   {31'd0, imem_req},    32'd1);
      chk("fetch_addr",  imem_addr,            m_pc);
      chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
      chk("fetch_fault", {31'd0, fault},       32'd0);
      chk("fetch_instr", instr,                m_instr);
      chk("fetch_ret",   retired,              m_ret);
      imem_ack    = (i == waits);
      imem_rdata  = (i == waits) ? data : $urandom;
      instr_ready = 1'($urandom);
      junk_decisions();
      step();
    end
    imem_ack = 1'b0;
    m_instr  = data;
  endtask

  task automatic do_issue(input int stalls, input bit src, input bit jmp,
                          input logic [31:0] bt);
    logic [31:0] p4, nxt;
    for (int i = 0; i <= stalls; i++) begin
      chk("issue_valid", {31'd0, instr_valid}, 32'd1);
      chk("issue_req",   {31'd0, imem_req},    32'd0);
      chk("issue_instr", instr,                m_instr);
      chk("issue_op",    {26'd0, op},          m_instr >> 26);
      chk("issue_funct", {26'd0, funct},       m_instr % 64);
      chk("issue_p4",    pc_plus4,             m_pc + 32'd4);
      chk("issue_ret",   retired,              m_ret);
      chk("issue_addr",  imem_addr,            m_pc);
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      if (i < stalls) begin
        instr_ready = 1'b0;
        junk_decisions();
      end else begin
        instr_ready   = 1'b1;
        pc_src        = src;
        jump          = jmp;
        branch_target = bt;
      end
      step();
    end
    instr_ready = 1'b0;
    imem_ack    = 1'b0;
    p4 = m_pc + 32'd4;
    if (jmp)      nxt = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    else if (src) nxt = bt;
    else          nxt = p4;
    m_ret = m_ret + 32'd1;
    if (nxt % 4 == 0) m_pc = nxt;
  endtask

  task automatic do_halt_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk("halt_fault", {31'd0, fault},       32'd1);
      chk("halt_req",   {31'd0, imem_req},    32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_addr",  imem_addr,            m_pc);
      chk("halt_ret",   retired,              m_ret);
      chk("halt_instr", instr,                m_instr);
      imem_ack    = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      junk_decisions();
      step();
    end
  endtask

  initial begin
    reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 32'd0;
    instr_ready   = 1'b0;
    pc_src        = 1'b0;
    jump          = 1'b0;
    branch_target = 32'd0;

    // Reset with a stale ack present, then straight-line code.
    do_reset(2, 1'b1);
    do_idle(1'b0);
    chk("w_fetch_req",  {31'd0, w_imem_req}, 32'd1);
    chk("w_fetch_addr", w_imem_addr,         32'hFFFF_FFFC);
    chk("w_ret_init",   w_retired,           32'hFFFF_FFFF);
    chk("w_fault",      {31'd0, w_fault},    32'd0);
    do_fetch(0, 32'h2008_0005);
    chk("w_valid",      {31'd0, w_instr_valid}, 32'd1);
    chk("w_instr",      w_instr,                32'h2008_0005);
    chk("w_op",         {26'd0, w_op},          32'h08);
    chk("w_funct",      {26'd0, w_funct},       32'h05);
    chk("w_p4_wrap",    w_pc_plus4,             32'd0);
    do_issue(0, 1'b0, 1'b0, 32'd0);
    chk("w_addr_wrap",  w_imem_addr,            32'd0);
    chk("w_ret_wrap",   w_retired,              32'd0);
    for (int k = 0; k < 2; k++) begin
      do_fetch(0, 32'h2008_0005);
      do_issue(0, 1'b0, 1'b0, 32'd0);
    end
    chk("straight_ret3", retired, 32'd3);

    // Memory wait states and datapath stall.
    do_fetch(3, 32'h0123_4567);
    do_issue(2, 1'b0, 1'b0, 32'd0);

    // Taken branch from PC 0x10, then jump beating pc_src.
    chk("pc_is_0x10", imem_addr, 32'h10);
    do_fetch(0, 32'h1000_0003);
    do_issue(0, 1'b1, 1'b0, 32'h40);
    chk("branch_addr", imem_addr, 32'h40);
    do_fetch(1, 32'h0800_0020);
    do_issue(1, 1'b1, 1'b1, 32'h100);
    chk("jump_addr", imem_addr, 32'h80);

    // Randomized instruction stream with aligned targets.
    for (int k = 0; k < 40; k++) begin
      do_fetch(int'($urandom_range(2, 0)), $urandom);
      do_issue(int'($urandom_range(2, 0)), 1'($urandom), ($urandom_range(3, 0) == 0),
               $urandom & 32'h0000_0FFC);
    end

    // Misaligned branch target halts until reset.
    do_fetch(0, $urandom);
    do_issue(1, 1'b1, 1'b0, 32'h42);
    do_halt_check(4);

    // Reset mid-fetch; ack arriving just after reset must be ignored.
    do_reset(1, 1'b0);
    do_idle(1'b0);
    do_fetch(0, 32'hDEAD_BEE0);
    do_issue(0, 1'b0, 1'b0, 32'd0);
    imem_ack = 1'b0;
    chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_pc    = 32'd0;
    m_instr = 32'd0;
    m_ret   = 32'd0;
    chk("mf_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("mf_rst_instr", instr,             32'd0);
    chk("mf_rst_addr",  imem_addr,         32'd0);
    do_idle(1'b1);
    do_fetch(1, 32'h2008_0005);
    do_issue(0, 1'b0, 1'b0, 32'd0);
    chk("restart_addr", imem_addr, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the main controller. It holds the PC and fetches one instruction per step over a simple req/ack instruction-memory handshake. It presents the latched instruction and its Op/Funct fields to the controller. It then consumes the controller's PCSrc/Jump decision, plus the datapath's branch target, to form the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned fetch address, equal to the current PC.
- imem_ack  in  1  read data valid this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, captured when imem_ack=1.
- instr  out  32  latched instruction register (IR).
- op  out  6  instr[31:26], to the controller Op input.
- funct  out  6  instr[5:0], to the controller Funct input.
- instr_valid  out  1  IR holds an instruction awaiting execution.
- instr_ready  in  1  datapath completes the instruction this cycle.
- pc_plus4  out  32  PC+4 of the instruction in IR.
- pc_src  in  1  controller branch-taken decision.
- jump  in  1  controller jump decision.
- branch_target  in  32  datapath branch target (pc_plus4 + (signimm<<2)).
- fault  out  1  sticky misaligned-target fault.
- retired  out  32  count of completed instructions.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, retired=0. All single-bit outputs are 0.
- IDLE: no request. Next state is always FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, go to ISSUE.
  - Otherwise stay in FETCH with the address held stable.
- ISSUE: instr_valid=1; op and funct are driven from the IR.
  - If instr_ready=0: hold all state.
  - If instr_ready=1: next = jump ? jtarget : (pc_src ? branch_target : pc+4), where jtarget = {pc_plus4[31:28], instr[25:0], 2'b00].
  - jump has priority over pc_src.
  - On completion, retired increments by 1 (modulo 2^32).
  - If next[1:0]==0: pc<=next, go to FETCH.
  - Otherwise: pc is unchanged, fault<=1, go to HALT.
- HALT: no requests, instr_valid=0, fault=1. Exit only via reset.
- pc_plus4 = pc + 32'd4 with 32-bit wrap; 32'hFFFF_FFFC wraps to 0.
- pc_src, jump and branch_target are ignored outside ISSUE, and ignored in ISSUE when instr_ready=0.
- imem_ack outside FETCH is ignored, including a stale ack arriving after reset.

## Timing
- The first request is asserted in the 2nd cycle after reset deasserts (IDLE, then FETCH).
- With imem_ack in the first FETCH cycle, instr_valid rises on the next cycle.
- Minimum of 2 cycles per instruction: FETCH with immediate ack, then ISSUE with instr_ready=1.
- Each memory wait cycle adds 1 cycle. Each cycle of instr_ready=0 adds 1 cycle.
- imem_req and instr_valid are Moore outputs decoded from the state register; they have no combinational path from any input.
- The redirect target is visible on imem_addr in the cycle after the completing ISSUE cycle.
- Reset asserted mid-FETCH or mid-ISSUE takes priority: the next cycle is IDLE with reset values, and the outstanding request is abandoned.

## Structure
- The shared package mips_pkg holds:
  - the state enum (IDLE/FETCH/ISSUE/HALT);
  - the instruction field positions (OP_HI=31, OP_LO=26, FUNCT_HI=5, FUNCT_LO=0, JIDX_HI=25);
  - the default RESET_PC.
- One combinational sub-module, pc_next, computes jtarget, applies the jump/pc_src priority, and checks alignment.
- The FSM, PC, IR and retired counter live in fetch_unit.

## Test plan
- Reset then straight-line fetch:
  - Stimulus: reset for 2 cycles; memory acks immediately with 32'h2008_0005, and instr_ready is held at 1.
  - Required: imem_addr is 0, then 4, then 8 on successive FETCH cycles; op=6'h08; retired=3 after 3 ISSUE cycles.
- Wait states and stall:
  - Stimulus: ack arrives after 3 FETCH cycles; instr_ready is held at 0 for 2 ISSUE cycles.
  - Required: imem_addr is stable throughout the waits; instr and retired are unchanged until completion.
- Taken branch, and jump priority:
  - Stimulus 1: PC=0x10, pc_src=1, branch_target=0x40. Required: next imem_addr=0x40.
  - Stimulus 2: instr=32'h0800_0020, jump=1 and pc_src=1 together. Required: next imem_addr=0x80.
- Misaligned target:
  - Stimulus: pc_src=1, branch_target=0x42.
  - Required: fault=1 the next cycle; imem_req stays 0; pc is unchanged; the state persists until reset.
- Reset mid-fetch:
  - Stimulus: assert reset while in FETCH waiting for ack; ack arrives the cycle after reset.
  - Required: the stale ack is ignored; the fetch restarts at RESET_PC with instr=0.
- Wrap-around:
  - Stimulus 1: RESET_PC=32'hFFFF_FFFC, sequential completion. Required: next imem_addr=0.
  - Stimulus 2: preload retired=32'hFFFF_FFFF. Required: retired wraps to 0.
